fifo_rd_ctrl: RTL and testbench

- Read-side controller of the dual-clock FIFO in the DSI transmit path; runs entirely in the read clock domain.
- Consumes the gray-coded write pointer from the write-domain gray counter and synchronizes it.
- Compares it with the local read pointer, drives the synchronous-read FIFO RAM, and presents data as a valid/ready stream.
- Returns its own gray read pointer to the write domain.

---
 rtl/fifo_rd_ctrl.sv | 86 ++++++++
 tb/tb_fifo_rd_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - read-side controller of the dual-clock DSI transmit FIFO
module fifo_rd_ctrl #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W:0]     wptr_gray,
    output logic [ADDR_W:0]     rptr_gray,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_re,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W:0]     level
);
    localparam int PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0]  sync_q [SYNC_STAGES];
    logic [PTR_W-1:0]  wsync_gray;
    logic [PTR_W-1:0]  wsync_bin;
    logic [PTR_W-1:0]  rptr_bin;
    logic [PTR_W-1:0]  next_rptr_bin;
    logic [DATA_W-1:0] buf_mem [2];
    logic [1:0]        buf_cnt;
    logic              pend;
    logic              hd;
    logic              tl;
    logic              empty;
    logic              pop;
    logic [2:0]        occ;

    // Plain flop chain; no logic between stages so each bit settles independently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= wptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign wsync_gray = sync_q[SYNC_STAGES-1];

    always_comb begin
        wsync_bin = '0;
        for (int i = 0; i < PTR_W; i++) wsync_bin[i] = ^(wsync_gray >> i);
    end

    assign empty     = (wsync_bin == rptr_bin);
    assign out_valid = (buf_cnt != 2'd0);
    assign out_data  = buf_mem[hd];
    assign pop       = out_valid && out_ready;

    // Words that will occupy the buffer after this edge if nothing new is issued.
    assign occ       = {1'b0, buf_cnt} + {2'b00, pend} - {2'b00, pop};
    assign ram_re    = !empty && (occ < 3'd2);
    assign ram_addr  = rptr_bin[ADDR_W-1:0];

    assign next_rptr_bin = rptr_bin + PTR_W'(ram_re);
    assign tl            = hd ^ buf_cnt[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr_bin   <= '0;
            rptr_gray  <= '0;
            pend       <= 1'b0;
            buf_cnt    <= 2'd0;
            hd         <= 1'b0;
            level      <= '0;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
        end else begin
            assert (!(pend && buf_cnt == 2'd2));
            rptr_bin  <= next_rptr_bin;
            rptr_gray <= next_rptr_bin ^ (next_rptr_bin >> 1);
            pend      <= ram_re;
            if (pend) buf_mem[tl] <= ram_rdata;
            if (pop) hd <= ~hd;
            buf_cnt   <= buf_cnt + {1'b0, pend} - {1'b0, pop};
            level     <= (wsync_bin - rptr_bin) + PTR_W'(pend) + PTR_W'(buf_cnt);
        end
    end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - self-checking bench for fifo_rd_ctrl
module tb_fifo_rd_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] wptr_gray = '0;
    logic [4:0] rptr_gray;
    logic [3:0] ram_addr;
    logic       ram_re;
    logic [7:0] ram_rdata = '0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] level;

    fifo_rd_ctrl #(.ADDR_W(4), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .wptr_gray(wptr_gray), .rptr_gray(rptr_gray),
        .ram_addr(ram_addr), .ram_re(ram_re), .ram_rdata(ram_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [16];
    always @(posedge clk) if (ram_re) ram_rdata <= mem[ram_addr];

    int          checks = 0;
    int          errors = 0;
    int unsigned wr_total = 0;
    int unsigned pop_total = 0;
    int unsigned issue_total = 0;
    logic [7:0]  exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] d);
        mem[wr_total[3:0]] = d;
        exp_q.push_back(d);
        wr_total++;
        wptr_gray = gray(wr_total[4:0]);
    endtask

    // Stream scoreboard: in-order exactly-once delivery, hold under stall, gray one-bit steps.
    logic       prev_ok = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic [4:0] prev_gray = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_ok    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_ok) check("gray_step", 32'($countones(prev_gray ^ rptr_gray) <= 1), 1);
            if (prev_stall) check("stall_hold", {out_valid, out_data}, {1'b1, prev_data});
            if (ram_re) issue_total++;
            if (out_valid && out_ready) begin
                pop_total++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got 0x%0h expected no word", out_data);
                end else begin
                    check("pop_data", out_data, exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_gray  = rptr_gray;
            prev_ok    = 1'b1;
        end
    end

    typedef struct {
        int         add;
        logic       ready;
        int         cycles;
        logic [4:0] lvl;
        logic       vld;
        logic [4:0] rg;
    } vec_t;
    vec_t tbl [6];

    initial begin
        int lat;
        int unsigned iss0;
        int unsigned pop0;
        int written;
        int cyc;

        tbl[0] = '{0,  1'b1, 8,  5'd0, 1'b0, 5'h02};
        tbl[1] = '{2,  1'b0, 8,  5'd2, 1'b1, 5'h07};
        tbl[2] = '{5,  1'b0, 8,  5'd7, 1'b1, 5'h07};
        tbl[3] = '{0,  1'b1, 12, 5'd0, 1'b0, 5'h0F};
        tbl[4] = '{1,  1'b0, 6,  5'd1, 1'b1, 5'h0E};
        tbl[5] = '{0,  1'b1, 6,  5'd0, 1'b0, 5'h0E};

        for (int i = 0; i < 4; i++) begin
            step();
            check("rst_valid", out_valid, 0);
            check("rst_re", ram_re, 0);
            check("rst_rptr", rptr_gray, 0);
            check("rst_level", level, 0);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check("idle_re", ram_re, 0);

        // gray(1)..gray(3), one step per clock; first word visible 4 edges after gray(1)
        write_word(8'h10);
        lat = 0;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 1) write_word(8'h11);
            if (e == 2) write_word(8'h12);
            if (lat == 0 && out_valid) lat = e;
        end
        check("first_valid_edge", lat, 4);

        for (int v = 0; v < 6; v++) begin
            out_ready = tbl[v].ready;
            for (int k = 0; k < tbl[v].add; k++) write_word(8'h10 + 8'(wr_total[3:0]));
            for (int c = 0; c < tbl[v].cycles; c++) step();
            check($sformatf("tbl%0d_level", v), level, tbl[v].lvl);
            check($sformatf("tbl%0d_valid", v), out_valid, tbl[v].vld);
            check($sformatf("tbl%0d_rptr", v), rptr_gray, tbl[v].rg);
        end

        // Full FIFO under backpressure, then back-to-back drain
        out_ready = 1'b0;
        iss0 = issue_total;
        for (int k = 0; k < 16; k++) write_word(8'h10 + 8'(wr_total[3:0]));
        for (int c = 0; c < 8; c++) step();
        check("full_level", level, 16);
        check("full_valid", out_valid, 1);
        check("full_issues", issue_total - iss0, 2);
        check("full_re_low", ram_re, 0);
        check("full_rptr", rptr_gray, 5'h0B);
        out_ready = 1'b1;
        pop0 = pop_total;
        for (int c = 0; c < 16; c++) step();
        check("drain_b2b", pop_total - pop0, 16);
        check("drain_empty", out_valid, 0);
        for (int c = 0; c < 4; c++) step();
        check("drain_rptr", rptr_gray, 5'h16);
        check("drain_level", level, 0);

        // Reset with words buffered and a read in flight
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) write_word(8'h40 + 8'(k));
        for (int c = 0; c < 8; c++) step();
        out_ready = 1'b1;
        step();
        rst = 1'b1;
        out_ready = 1'b0;
        exp_q.delete();
        wr_total = 0;
        pop_total = 0;
        wptr_gray = '0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_rptr", rptr_gray, 0);
        check("mid_rst_level", level, 0);
        step();
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        iss0 = issue_total;
        for (int c = 0; c < 10; c++) step();
        check("post_rst_valid", out_valid, 0);
        check("post_rst_issues", issue_total - iss0, 0);
        write_word(8'hA0);
        write_word(8'hA1);
        for (int c = 0; c < 8; c++) step();
        check("post_rst_pops", pop_total, 2);
        check("post_rst_rptr", rptr_gray, 5'h03);
        check("post_rst_level", level, 0);

        // Random backpressure across the 31->0 pointer wrap
        written = 0;
        cyc = 0;
        while ((written < 40 || exp_q.size() != 0) && cyc < 3000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (written < 40 && (wr_total - pop_total) < 16 && $urandom_range(0, 3) != 0) begin
                write_word(8'($urandom));
                written++;
            end
            step();
            cyc++;
            check("level_bound", 32'(level <= 5'd16), 1);
        end
        check("rand_written", written, 40);
        check("rand_drained", exp_q.size(), 0);
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) step();
        check("rand_level", level, 0);
        check("rand_valid", out_valid, 0);
        check("rand_rptr", rptr_gray, gray(wr_total[4:0]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
